memory_game_fsm: RTL and testbench
==================================

Name: memory_game_fsm

Overview:
- Main game sequencer for the memory game; the stage directly upstream of the qini/qw/qr round-flag counter.
- Generates a pseudo-random colour sequence, plays it on the LEDs, then checks the player's button presses one by one.
- Drives the one-hot state strobes qini (init), qw (wait for player), qr (read/compare) that the downstream counter consumes, and reports win/lose.

Parameters:
- MAX_LEN, 16, sequence length needed to win (2..31).
- SHOW_TICKS, 25000000, clock cycles each LED stays lit during playback (>=1).
- GAP_TICKS, 12500000, dark cycles after each lit LED (>=1).
- SEED, 8'hA5, LFSR reset value (must be non-zero).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle pulse (debounced upstream); begins a new game.
- btn  input  4  player buttons, debounced single-cycle pulses; bit k = colour k.
- led  output  4  one-hot colour display.
- qini  output  1  high while in INI.
- qw  output  1  high while in WAIT.
- qr  output  1  high while in READ.
- level  output  5  current round length (0 in INI).
- win  output  1  high while in WIN.
- lose  output  1  high while in LOSE.

Behaviour:
- Reset (reset=0, asynchronous): state=INI, led=0, qini=1, qw=qr=0, level=0, win=lose=0, lfsr=SEED, idx=0, tick counter=0.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4. Shifts every cycle in every state except during reset, so player timing seeds the colours. Colour sample = lfsr[1:0].
- Sequence store: MAX_LEN x 2-bit registers, no reset needed. Only entries below level are ever read.
- All outputs are registered. qini/qw/qr/win/lose are one-hot decodes of the state; all five are 0 in SHOW.
- INI:
  - On start: seq[0]=colour sample, level=1, idx=0, go to SHOW.
- SHOW:
  - For idx = 0..level-1: led=onehot(seq[idx]) for exactly SHOW_TICKS cycles, then led=0 for exactly GAP_TICKS cycles.
  - The first SHOW cycle already drives the LED.
  - After the last gap: idx=0, go to WAIT.
  - start and btn are ignored.
- WAIT:
  - led=0.
  - btn==0: stay.
  - Any non-zero btn: latch it into btn_q and go to READ next cycle.
  - btn is sampled only while the state register equals WAIT; a press in the cycle SHOW exits is lost.
- READ (exactly one cycle):
  - Compare btn_q against onehot(seq[idx]). Multi-bit btn_q is always a mismatch.
  - Mismatch: go to LOSE.
  - Match, idx<level-1: idx++, go to WAIT.
  - Match, idx==level-1, level==MAX_LEN: go to WIN.
  - Match, idx==level-1, otherwise: seq[level]=colour sample, level++, idx=0, go to SHOW.
- WIN: led=4'hF, win=1; level holds at MAX_LEN.
- LOSE: led=onehot(seq[idx]) (the expected colour), lose=1; level holds.
- Restart: start in WIN or LOSE behaves exactly as in INI (new game, win/lose cleared). start in SHOW/WAIT/READ is ignored.
- Reset mid-operation: immediate return to the reset values, whatever the state.
- Simultaneous start and btn in WIN/LOSE: start wins; btn is ignored.

Test Plan:
- Reset/idle: hold reset=0, release, wait 10 cycles with no stimulus -> qini=1, led=0, level=0, win=lose=0 throughout.
- Playback timing (SHOW_TICKS=4, GAP_TICKS=2, MAX_LEN=4): pulse start -> next cycle qini=0, led one-hot for exactly 4 cycles then 0 for 2 cycles, then qw=1, level=1.
- Correct round: in WAIT press btn equal to the shown colour -> qr=1 for exactly 1 cycle, then SHOW with level=2 whose first colour matches round 1. Two LED flashes (12 cycles total), then qw=1.
- Wrong/multi press: in WAIT press btn=4'b0011 (or a wrong single bit) -> one READ cycle, then lose=1 and led=expected colour. A later start pulse -> level=1, lose=0, SHOW.
- Full win (MAX_LEN=4): echo every shown colour correctly through 4 rounds -> win=1, led=4'hF, level=4. btn presses are ignored afterwards.
- Async reset in WAIT mid-game (level=3): drop reset between clock edges -> qini=1, led=0, level=0 immediately, without a clock edge. start pulses while in SHOW are ignored (level unchanged).

Source files
------------

// File: rtl/memory_game_fsm.sv
// Memory game sequencer: builds a random colour sequence, plays it on the LEDs,
// then checks the player's presses and reports win/lose.
module memory_game_fsm #(
  parameter int unsigned MAX_LEN    = 16,
  parameter int unsigned SHOW_TICKS = 25000000,
  parameter int unsigned GAP_TICKS  = 12500000,
  parameter logic [7:0]  SEED       = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] btn,
  output logic [3:0] led,
  output logic       qini,
  output logic       qw,
  output logic       qr,
  output logic [4:0] level,
  output logic       win,
  output logic       lose
);

  localparam int unsigned IW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned DEPTH = 1 << IW;
  localparam int unsigned TMAX  = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
  localparam int unsigned TW    = (TMAX > 1) ? $clog2(TMAX) : 1;

  typedef enum logic [2:0] {
    S_INI, S_SHOW, S_WAIT, S_READ, S_WIN, S_LOSE
  } state_t;

  state_t          state, state_n;
  logic [7:0]      lfsr;
  logic [1:0]      seq [DEPTH];
  logic [4:0]      idx;
  logic [TW-1:0]   tick;
  logic            gap;
  logic [3:0]      btn_q;

  logic [1:0]      colour;
  logic [3:0]      exp_led;
  logic            last, lit_end, gap_end, new_game, matched, grow;
  logic [3:0]      led_n;

  function automatic logic [3:0] onehot(input logic [1:0] c);
    return 4'b0001 << c;
  endfunction

  // Shared decode terms used by the next-state, datapath and output logic
  always_comb begin
    colour   = lfsr[1:0];
    exp_led  = onehot(seq[IW'(idx)]);
    last     = (idx == level - 5'd1);
    lit_end  = !gap && (tick == TW'(SHOW_TICKS - 1));
    gap_end  = gap && (tick == TW'(GAP_TICKS - 1));
    new_game = start && (state == S_INI || state == S_WIN || state == S_LOSE);
    matched  = (btn_q == exp_led);
    grow     = (state == S_READ) && matched && last && (level != 5'(MAX_LEN));
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_INI;
    else        state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      S_INI, S_WIN, S_LOSE: if (start) state_n = S_SHOW;
      S_SHOW:               if (gap_end && last) state_n = S_WAIT;
      S_WAIT:               if (btn != 4'h0) state_n = S_READ;
      S_READ: begin
        if (!matched)                    state_n = S_LOSE;
        else if (!last)                  state_n = S_WAIT;
        else if (level == 5'(MAX_LEN))   state_n = S_WIN;
        else                             state_n = S_SHOW;
      end
      default:              state_n = S_INI;
    endcase
  end

  // Datapath: LFSR free-runs; level/index/playback timer follow the state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr  <= SEED;
      level <= 5'd0;
      idx   <= 5'd0;
      tick  <= '0;
      gap   <= 1'b0;
      btn_q <= 4'h0;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      case (state)
        S_INI, S_WIN, S_LOSE: begin
          if (start) begin
            level <= 5'd1;
            idx   <= 5'd0;
            tick  <= '0;
            gap   <= 1'b0;
          end
        end
        S_SHOW: begin
          if (lit_end) begin
            tick <= '0;
            gap  <= 1'b1;
          end else if (gap_end) begin
            tick <= '0;
            gap  <= 1'b0;
            idx  <= last ? 5'd0 : idx + 5'd1;
          end else begin
            tick <= tick + TW'(1);
          end
        end
        S_WAIT: if (btn != 4'h0) btn_q <= btn;
        S_READ: begin
          if (matched && !last) idx <= idx + 5'd1;
          if (grow) begin
            level <= level + 5'd1;
            idx   <= 5'd0;
            tick  <= '0;
            gap   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Sequence store: appended at game start and after each completed round
  always_ff @(posedge clk) begin
    if (new_game)  seq[0]          <= colour;
    else if (grow) seq[IW'(level)] <= colour;
  end

  // Output decode of the upcoming state, so registered outputs track the state register
  always_comb begin
    led_n = 4'h0;
    case (state_n)
      S_SHOW: begin
        if (state != S_SHOW)  led_n = (state == S_READ) ? onehot(seq[0]) : onehot(colour);
        else if (lit_end)     led_n = 4'h0;
        else if (gap_end)     led_n = onehot(seq[IW'(idx + 5'd1)]);
        else if (gap)         led_n = 4'h0;
        else                  led_n = exp_led;
      end
      S_WIN:   led_n = 4'hF;
      S_LOSE:  led_n = exp_led;
      default: led_n = 4'h0;
    endcase
  end

  // Output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led  <= 4'h0;
      qini <= 1'b1;
      qw   <= 1'b0;
      qr   <= 1'b0;
      win  <= 1'b0;
      lose <= 1'b0;
    end else begin
      led  <= led_n;
      qini <= (state_n == S_INI);
      qw   <= (state_n == S_WAIT);
      qr   <= (state_n == S_READ);
      win  <= (state_n == S_WIN);
      lose <= (state_n == S_LOSE);
    end
  end

endmodule

// File: tb/tb_memory_game_fsm.sv
// Directed self-checking bench for memory_game_fsm with short playback timing.
module tb_memory_game_fsm;

  localparam int unsigned MAX_LEN = 4;
  localparam int unsigned SHOW    = 4;
  localparam int unsigned GAP     = 2;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [3:0] btn   = 4'h0;
  logic [3:0] led;
  logic       qini, qw, qr, win, lose;
  logic [4:0] level;

  memory_game_fsm #(
    .MAX_LEN(MAX_LEN), .SHOW_TICKS(SHOW), .GAP_TICKS(GAP), .SEED(8'hA5)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .btn(btn), .led(led),
    .qini(qini), .qw(qw), .qr(qr), .level(level), .win(win), .lose(lose)
  );

  always #5 clk = ~clk;

  // Reference LFSR: Fibonacci taps 8,6,5,4, runs whenever reset is released
  logic [7:0] m_lfsr;
  always @(posedge clk or negedge reset) begin
    if (!reset) m_lfsr <= 8'hA5;
    else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [1:0] exp_seq [8];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic logic [3:0] oh(input logic [1:0] c);
    logic [3:0] one;
    one = 4'b0001;
    return one << c;
  endfunction

  // Start pulse (optionally with a simultaneous button press); returns in first SHOW cycle
  task automatic begin_game(input logic [3:0] b);
    start = 1'b1;
    btn   = b;
    exp_seq[0] = m_lfsr[1:0];
    @(negedge clk);
    start = 1'b0;
    btn   = 4'h0;
  endtask

  // Check a whole playback of lvl colours, then the WAIT state that follows
  task automatic show_check(input int lvl, input bit poke_start);
    for (int i = 0; i < lvl; i++) begin
      for (int t = 0; t < int'(SHOW + GAP); t++) begin
        check_eq("show_led", 32'(led), 32'((t < int'(SHOW)) ? oh(exp_seq[i]) : 4'h0));
        check_eq("show_flags", 32'({qini, qw, qr, win, lose}), 32'(5'b00000));
        check_eq("show_level", 32'(level), 32'(lvl));
        start = poke_start && (t == 1);
        @(negedge clk);
      end
    end
    start = 1'b0;
    check_eq("wait_entry", 32'({qini, qw, qr, led}), 32'({3'b010, 4'h0}));
    check_eq("wait_level", 32'(level), 32'(lvl));
  endtask

  // One button press from WAIT; checks the single READ cycle and returns the colour sampled there
  task automatic press(input logic [3:0] b, output logic [1:0] sample);
    btn = b;
    @(negedge clk);
    btn = 4'h0;
    check_eq("read_cycle", 32'({qini, qw, qr, win, lose, led}), 32'({5'b00100, 4'h0}));
    sample = m_lfsr[1:0];
    @(negedge clk);
  endtask

  // Echo the whole sequence of length lvl correctly
  task automatic echo_round(input int lvl);
    logic [1:0] s;
    s = 2'd0;
    for (int j = 0; j < lvl; j++) begin
      press(oh(exp_seq[j]), s);
      if (j < lvl - 1)
        check_eq("back_to_wait", 32'({qw, qr, level}), 32'({2'b10, 5'(lvl)}));
    end
    if (lvl == int'(MAX_LEN))
      check_eq("win_state", 32'({qini, qw, qr, win, lose, led, level}),
               32'({5'b00010, 4'hF, 5'(MAX_LEN)}));
    else
      exp_seq[lvl] = s;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] s;
    // Reset and idle
    repeat (3) @(negedge clk);
    check_eq("in_reset", 32'({qini, qw, qr, win, lose, led, level}), 32'({5'b10000, 4'h0, 5'd0}));
    reset = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check_eq("idle", 32'({qini, qw, qr, win, lose, led, level}), 32'({5'b10000, 4'h0, 5'd0}));
    end

    // Full game to WIN; start pokes during the level-3 playback are ignored
    begin_game(4'h0);
    show_check(1, 1'b0);
    repeat (2) begin
      @(negedge clk);
      check_eq("wait_hold", 32'({qw, qr, led, level}), 32'({2'b10, 4'h0, 5'd1}));
    end
    for (int lvl = 1; lvl <= int'(MAX_LEN); lvl++) begin
      echo_round(lvl);
      if (lvl < int'(MAX_LEN)) show_check(lvl + 1, lvl == 2);
    end
    btn = 4'h1;
    @(negedge clk);
    btn = 4'h8;
    @(negedge clk);
    btn = 4'h0;
    check_eq("win_ignores_btn", 32'({qini, qw, qr, win, lose, led, level}),
             32'({5'b00010, 4'hF, 5'd4}));

    // Restart from WIN, lose on a multi-bit press
    begin_game(4'h0);
    show_check(1, 1'b0);
    press(4'b0011, s);
    check_eq("lose_multi", 32'({qini, qw, qr, win, lose, led, level}),
             32'({5'b00001, oh(exp_seq[0]), 5'd1}));

    // Start together with a button in LOSE: start wins
    begin_game(4'h2);
    show_check(1, 1'b0);
    echo_round(1);
    show_check(2, 1'b0);
    press(oh(exp_seq[0] + 2'd1), s);
    check_eq("lose_wrong", 32'({qini, qw, qr, win, lose, led, level}),
             32'({5'b00001, oh(exp_seq[0]), 5'd2}));
    @(negedge clk);
    check_eq("lose_hold", 32'({lose, led, level}), 32'({1'b1, oh(exp_seq[0]), 5'd2}));

    // Async reset while waiting at level 3
    begin_game(4'h0);
    show_check(1, 1'b0);
    echo_round(1);
    show_check(2, 1'b1);
    echo_round(2);
    show_check(3, 1'b0);
    #2 reset = 1'b0;
    #1 check_eq("async_reset", 32'({qini, qw, qr, win, lose, led, level}),
                32'({5'b10000, 4'h0, 5'd0}));
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("post_reset_idle", 32'({qini, qw, led, level}), 32'({2'b10, 4'h0, 5'd0}));
    begin_game(4'h0);
    show_check(1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
